// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: circular trace buffer of per-stage pipeline PCs and
// stall/flush flags. arm_i clears and starts capture, trig_i starts a
// post-trigger window of POST_TRIG valid cycles, after which the buffer
// freezes in DONE and entries are popped oldest-first through rd_data_o.
// Optional feature macro: PIPE_TRACE_TIMESTAMP_EN prepends a free-running
// XLEN-bit cycle stamp to every entry.
`timescale 1ns/1ps

module pipe_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int NSTAGE    = 5,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
`ifdef PIPE_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W  = XLEN*(NSTAGE+1) + 2*NSTAGE,
`else
  localparam int ENTRY_W  = XLEN*NSTAGE + 2*NSTAGE,
`endif
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     arm_i,
  input  logic                     trig_i,
  input  logic                     valid_i,
  input  logic [NSTAGE*XLEN-1:0]   stage_pc_i,
  input  logic [NSTAGE-1:0]        stall_i,
  input  logic [NSTAGE-1:0]        flush_i,
  input  logic                     rd_en_i,
  output logic [ENTRY_W-1:0]       rd_data_o,
  output logic                     rd_valid_o,
  output logic [AW:0]              count_o,
  output logic [1:0]               state_o,
  output logic                     overflow_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] POST    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int CW  = AW + 1;
  localparam int PCW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [PCW-1:0]     post_cnt;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] entry;
  logic               write_en;
  logic               read_en;
  logic               full;

`ifdef PIPE_TRACE_TIMESTAMP_EN
  logic [XLEN-1:0] stamp;

  // Free-running cycle stamp, wraps naturally at XLEN bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stamp <= '0;
    else       stamp <= stamp + 1'b1;
  end

  assign entry = {stamp, flush_i, stall_i, stage_pc_i};
`else
  assign entry = {flush_i, stall_i, stage_pc_i};
`endif

  // arm_i has priority over both capture writes and readout pops
  assign write_en = !arm_i && valid_i && (state_o == CAPTURE || state_o == POST);
  assign read_en  = !arm_i && rd_en_i && (state_o == DONE) && (count_o != '0);
  assign full     = (count_o == CW'(DEPTH));

  // Control: state machine, pointers, occupancy, overflow and post counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_o    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      post_cnt   <= '0;
      overflow_o <= 1'b0;
    end else if (arm_i) begin
      state_o    <= CAPTURE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      post_cnt   <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (write_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (full) begin
          // Oldest entry is being overwritten: drop it from the read side
          rd_ptr     <= rd_ptr + 1'b1;
          overflow_o <= 1'b1;
        end else begin
          count_o <= count_o + 1'b1;
        end
      end
      if (read_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        count_o <= count_o - 1'b1;
      end
      case (state_o)
        CAPTURE: begin
          if (trig_i) begin
            if (POST_TRIG == 0) begin
              state_o <= DONE;
            end else begin
              post_cnt <= PCW'(POST_TRIG);
              state_o  <= POST;
            end
          end
        end
        POST: begin
          if (valid_i) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == PCW'(1)) state_o <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Entry storage: plain write port, contents survive reset
  always_ff @(posedge clk_i) begin
    if (write_en) mem[wr_ptr] <= entry;
  end

  // Registered readout: one-cycle latency, data held until next pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= read_en;
      if (read_en) rd_data_o <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Testbench for pipe_trace_buffer: table-driven sequence, hand-written
// corner cases, and randomized traffic against a queue-based model.
`timescale 1ns/1ps

module tb_pipe_trace_buffer;

  localparam int XLEN   = 32;
  localparam int NSTAGE = 5;
  localparam int DEPTH  = 16;
  localparam int PW     = NSTAGE*XLEN;
`ifdef PIPE_TRACE_TIMESTAMP_EN
  localparam int EW = XLEN*(NSTAGE+1) + 2*NSTAGE;
`else
  localparam int EW = XLEN*NSTAGE + 2*NSTAGE;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0, trig = 1'b0, valid = 1'b0, rd_en = 1'b0;
  logic [PW-1:0]     pcs   = '0;
  logic [NSTAGE-1:0] stall = '0, flush = '0;

  logic [EW-1:0] rd_data,  rd_data0;
  logic          rd_valid, rd_valid0;
  logic [CW-1:0] count,    count0;
  logic [1:0]    state,    state0;
  logic          ovf,      ovf0;

  int checks   = 0;
  int failures = 0;

  pipe_trace_buffer #(.XLEN(XLEN), .NSTAGE(NSTAGE), .DEPTH(DEPTH), .POST_TRIG(4)) dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .trig_i(trig), .valid_i(valid),
    .stage_pc_i(pcs), .stall_i(stall), .flush_i(flush), .rd_en_i(rd_en),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .count_o(count),
    .state_o(state), .overflow_o(ovf));

  pipe_trace_buffer #(.XLEN(XLEN), .NSTAGE(NSTAGE), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .trig_i(trig), .valid_i(valid),
    .stage_pc_i(pcs), .stall_i(stall), .flush_i(flush), .rd_en_i(rd_en),
    .rd_data_o(rd_data0), .rd_valid_o(rd_valid0), .count_o(count0),
    .state_o(state0), .overflow_o(ovf0));

  always #5 clk = ~clk;

`ifdef PIPE_TRACE_TIMESTAMP_EN
  logic [XLEN-1:0] cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 1'b1;
  end
`endif

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    arm = 0; trig = 0; valid = 0; rd_en = 0; stall = '0; flush = '0;
  endtask

  // Stage k holds the instruction that was fetched 4*k bytes earlier
  function automatic logic [PW-1:0] mkpc(input logic [XLEN-1:0] f);
    logic [PW-1:0] r;
    for (int k = 0; k < NSTAGE; k++) r[k*XLEN +: XLEN] = f - XLEN'(4*k);
    return r;
  endfunction

  function automatic logic [EW-1:0] cur_entry();
`ifdef PIPE_TRACE_TIMESTAMP_EN
    return {cyc, flush, stall, pcs};
`else
    return {flush, stall, pcs};
`endif
  endfunction

  // ---------------- reference model ----------------
  logic [EW-1:0] mq[$];
  int            mst, mpost;
  bit            movf, mrv;
  logic [EW-1:0] mlast;

  task automatic model_reset();
    mq.delete(); mst = 0; mpost = 0; movf = 0; mrv = 0; mlast = '0;
  endtask

  task automatic model_push(input logic [EW-1:0] e);
    mq.push_back(e);
    if (mq.size() > DEPTH) begin
      void'(mq.pop_front());
      movf = 1;
    end
  endtask

  // Model of the POST_TRIG=4 instance, applied for one clock edge
  task automatic model_step(input logic [EW-1:0] e);
    mrv = 0;
    if (arm) begin
      mq.delete(); movf = 0; mst = 1; mpost = 0;
    end else begin
      case (mst)
        1: begin
          if (valid) model_push(e);
          if (trig) begin mpost = 4; mst = 2; end
        end
        2: if (valid) begin
          model_push(e);
          mpost--;
          if (mpost == 0) mst = 3;
        end
        3: if (rd_en && mq.size() > 0) begin
          mlast = mq.pop_front();
          mrv = 1;
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- table ----------------
  typedef struct {
    bit arm, trig, valid, rd;
    logic [XLEN-1:0] fpc;
    logic [NSTAGE-1:0] st, fl;
    int est, ecnt;
    bit eovf, erv;
    logic [XLEN-1:0] epc;
    logic [NSTAGE-1:0] est_f, efl;
  } vec_t;

  function automatic vec_t v(bit a, bit t, bit vl, bit r, logic [XLEN-1:0] f,
                             logic [NSTAGE-1:0] s, logic [NSTAGE-1:0] fl,
                             int es, int ec, bit eo, bit er,
                             logic [XLEN-1:0] ep, logic [NSTAGE-1:0] esf,
                             logic [NSTAGE-1:0] efl);
    vec_t x;
    x.arm = a; x.trig = t; x.valid = vl; x.rd = r; x.fpc = f; x.st = s; x.fl = fl;
    x.est = es; x.ecnt = ec; x.eovf = eo; x.erv = er; x.epc = ep; x.est_f = esf; x.efl = efl;
    return x;
  endfunction

  vec_t tv[15];
  logic [EW-1:0] held;
  int trate;

  initial begin
    tv[0]  = v(0,0,0,1, 32'h0,        0,      0,      0,0,0,0, 0,0,0);
    tv[1]  = v(0,1,1,0, 32'h1234,     0,      0,      0,0,0,0, 0,0,0);
    tv[2]  = v(1,0,0,0, 32'h0,        0,      0,      1,0,0,0, 0,0,0);
    tv[3]  = v(0,0,1,0, 32'h80000000, 5'b00011, 5'b00100, 1,1,0,0, 0,0,0);
    tv[4]  = v(0,0,1,0, 32'h80000004, 0,      0,      1,2,0,0, 0,0,0);
    tv[5]  = v(0,1,1,0, 32'h80000008, 0,      0,      2,3,0,0, 0,0,0);
    tv[6]  = v(0,0,0,0, 32'h0,        0,      0,      2,3,0,0, 0,0,0);
    tv[7]  = v(0,1,1,0, 32'h8000000C, 0,      0,      2,4,0,0, 0,0,0);
    tv[8]  = v(0,0,1,0, 32'h80000010, 0,      0,      2,5,0,0, 0,0,0);
    tv[9]  = v(0,0,1,0, 32'h80000014, 0,      0,      2,6,0,0, 0,0,0);
    tv[10] = v(0,0,1,0, 32'h80000018, 0,      0,      3,7,0,0, 0,0,0);
    tv[11] = v(0,0,1,0, 32'h8000001C, 0,      0,      3,7,0,0, 0,0,0);
    tv[12] = v(0,0,0,1, 32'h0,        0,      0,      3,6,0,1, 32'h80000000, 5'b00011, 5'b00100);
    tv[13] = v(1,0,0,1, 32'h0,        0,      0,      1,0,0,0, 0,0,0);
    tv[14] = v(0,0,0,1, 32'h0,        0,      0,      1,0,0,0, 0,0,0);

    // Reset state
    idle();
    #12;
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rv", rd_valid, 0);
    check("rst_data", rd_data, 0);
    tick();
    rst = 0;

    // Table: arm, capture, post window, pop with flags, arm-beats-read
    for (int i = 0; i < 15; i++) begin
      arm = tv[i].arm; trig = tv[i].trig; valid = tv[i].valid; rd_en = tv[i].rd;
      pcs = mkpc(tv[i].fpc); stall = tv[i].st; flush = tv[i].fl;
      tick();
      check($sformatf("tv%0d_state", i), state, tv[i].est);
      check($sformatf("tv%0d_count", i), count, tv[i].ecnt);
      check($sformatf("tv%0d_ovf", i), ovf, tv[i].eovf);
      check($sformatf("tv%0d_rv", i), rd_valid, tv[i].erv);
      if (tv[i].erv) begin
        check($sformatf("tv%0d_pcs", i), rd_data[PW-1:0], mkpc(tv[i].epc));
        check($sformatf("tv%0d_stall", i), rd_data[PW +: NSTAGE], tv[i].est_f);
        check($sformatf("tv%0d_flush", i), rd_data[PW+NSTAGE +: NSTAGE], tv[i].efl);
      end
    end
    check("hold_after_pop", rd_data[PW-1:0], mkpc(32'h80000000));
    idle();

    // Overwrite: 20 valids, trigger on last, no post window (dut0)
    arm = 1; tick(); arm = 0;
    for (int n = 0; n < 20; n++) begin
      valid = 1; trig = (n == 19); pcs = mkpc(32'h80000000 + 32'(4*n));
      tick();
    end
    idle();
    check("ovr_state", state0, 3);
    check("ovr_count", count0, 16);
    check("ovr_ovf", ovf0, 1);
    rd_en = 1; tick(); rd_en = 0;
    check("ovr_rv", rd_valid0, 1);
    check("ovr_first_pc", rd_data0[XLEN-1:0], 32'h80000010);
    check("ovr_count_pop", count0, 15);

    // Readout drains to zero; extra pop ignored (dut0)
    arm = 1; tick(); arm = 0;
    valid = 1; pcs = mkpc(32'hA0); tick();
    trig = 1; pcs = mkpc(32'hA4); tick();
    idle();
    check("drain_state", state0, 3);
    check("drain_count", count0, 2);
    for (int r = 0; r < 3; r++) begin
      rd_en = 1; tick();
      check($sformatf("drain_rv%0d", r), rd_valid0, (r < 2) ? 1 : 0);
      if (r < 2) check($sformatf("drain_pc%0d", r), rd_data0[XLEN-1:0], 32'hA0 + 32'(4*r));
    end
    rd_en = 0;
    check("drain_count_end", count0, 0);
    check("drain_hold", rd_data0[XLEN-1:0], 32'hA4);

    // Asynchronous reset in POST with five entries stored
    arm = 1; tick(); arm = 0;
    valid = 1; pcs = mkpc(32'hB0); tick();
    trig = 1; tick(); trig = 0;
    for (int k = 0; k < 3; k++) tick();
    idle();
    check("pre_rst_state", state, 2);
    check("pre_rst_count", count, 5);
    #2 rst = 1;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_count", count, 0);
    #2 rst = 0;
    rd_en = 1; tick(); rd_en = 0;
    check("post_rst_rv", rd_valid, 0);
    valid = 1; trig = 1; tick(); idle();
    check("post_rst_noarm_state", state, 0);
    check("post_rst_noarm_count", count, 0);

`ifdef PIPE_TRACE_TIMESTAMP_EN
    // Timestamps: reset released so the next edge is cycle 0
    rst = 1; #1 rst = 0;
    for (int k = 0; k < 10; k++) tick();
    arm = 1; tick(); arm = 0;
    valid = 1; tick(); valid = 0;
    tick();
    valid = 1; trig = 1; tick(); trig = 0;
    for (int k = 0; k < 4; k++) tick();
    idle();
    rd_en = 1; tick();
    check("ts_first", rd_data[EW-1 -: XLEN], 11);
    tick(); rd_en = 0;
    check("ts_second", rd_data[EW-1 -: XLEN], 13);
`endif

    // Randomized traffic against the model
    rst = 1; #1 rst = 0;
    model_reset();
    trate = 8;
    for (int c = 0; c < 4000; c++) begin
      arm   = ($urandom % 40) == 0;
      if (arm) trate = ($urandom % 2) ? 8 : 64;
      trig  = ($urandom % trate) == 0;
      valid = $urandom % 2;
      rd_en = ($urandom % 3) == 0;
      for (int k = 0; k < NSTAGE; k++) pcs[k*XLEN +: XLEN] = $urandom;
      stall = NSTAGE'($urandom);
      flush = NSTAGE'($urandom);
      model_step(cur_entry());
      tick();
      check("rnd_state", state, mst);
      check("rnd_count", count, mq.size());
      check("rnd_ovf", ovf, movf);
      check("rnd_rv", rd_valid, mrv);
      check("rnd_data", rd_data, mlast);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buffer.md
PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC width per stage.
REQ-002 SHALL have parameter NSTAGE, default 5: pipeline stage count (F,D,E,M,WB order, F at index 0).
REQ-003 SHALL have parameter DEPTH, default 16: entry count, power of two, >=2.
REQ-004 SHALL have parameter POST_TRIG, default 4: valid cycles captured after trigger.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk_i  in  1  clock, all state on rising edge.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 arm_i  in  1  clear buffer and start capture.
REQ-009 trig_i  in  1  stop trigger.
REQ-010 valid_i  in  1  core cycle-update strobe; entry written only when high.
REQ-011 stage_pc_i  in  NSTAGE*XLEN  per-stage PC, stage k at bits [k*XLEN +: XLEN].
REQ-012 stall_i / flush_i  in  NSTAGE each  per-stage stall and flush flags.
REQ-013 rd_en_i  in  1  pop oldest entry.
REQ-014 rd_data_o  out  ENTRY_W  popped entry {flush, stall, PCs} (timestamp prepended per REQ-034).
REQ-015 rd_valid_o  out  1  rd_data_o valid, single-cycle pulse.
REQ-016 count_o  out  log2(DEPTH)+1  stored entry count.
REQ-017 state_o  out  2  IDLE=0, CAPTURE=1, POST=2, DONE=3.
REQ-018 overflow_o  out  1  at least one entry overwritten since arm.

Function
REQ-019 arm_i in any state SHALL zero write/read pointers, count_o and overflow_o and enter CAPTURE next cycle; no write on the arm cycle.
REQ-020 CAPTURE/POST with valid_i=1 SHALL write entry at wr_ptr, wr_ptr+1 mod DEPTH.
REQ-021 Write with count_o<DEPTH SHALL increment count_o.
REQ-022 Write with count_o==DEPTH SHALL overwrite oldest, advance rd_ptr, hold count_o, set overflow_o.
REQ-023 trig_i in CAPTURE SHALL still write that cycle's entry if valid_i, load post counter with POST_TRIG, go POST; POST_TRIG=0 goes directly DONE.
REQ-024 POST: each valid write decrements post counter; write that reaches 0 SHALL move to DONE next cycle.
REQ-025 trig_i in IDLE, POST, DONE SHALL be ignored; valid_i in IDLE, DONE SHALL be ignored.
REQ-026 DONE with rd_en_i and count_o>0 SHALL register oldest entry to rd_data_o, pulse rd_valid_o next cycle, rd_ptr+1, count_o-1.
REQ-027 rd_en_i with count_o==0 or outside DONE SHALL be ignored, rd_valid_o stays 0.
REQ-028 arm_i and rd_en_i same cycle: arm wins, no rd_valid_o.
REQ-029 rd_data_o SHALL hold last popped value until next pop.
REQ-030 Buffer storage SHALL be flops or inferred RAM with 1-cycle read latency; no combinational read path to rd_data_o.

Reset
REQ-031 rst_i SHALL asynchronously force state IDLE, pointers/count_o/post counter 0, overflow_o 0, rd_valid_o 0, rd_data_o 0.
REQ-032 rst_i mid-capture or mid-readout SHALL discard all entries; storage contents need not clear.
REQ-033 After rst_i release, first action SHALL require arm_i.

Configuration
REQ-034 Macro PIPE_TRACE_TIMESTAMP_EN defined: free-running XLEN-bit cycle counter (reset 0, +1 every clk, wraps) SHALL be stored as MSBs of each entry; ENTRY_W = XLEN*(NSTAGE+1)+2*NSTAGE.
REQ-035 Macro undefined: no counter logic; ENTRY_W = XLEN*NSTAGE+2*NSTAGE.

Verification
REQ-036 Arm, 3 valid cycles PCs F=0x80000000,0x80000004,0x80000008, trig on 3rd, POST_TRIG=4, 4 more valids -> DONE, count_o=7, overflow_o=0.
REQ-037 DEPTH=16, 20 valids with F PC 0x80000000+4n, trig at n=19, POST_TRIG=0 -> count_o=16, overflow_o=1, first pop F PC=0x80000010.
REQ-038 DONE with count_o=2, 3 consecutive rd_en_i -> 2 rd_valid_o pulses, third ignored, count_o=0.
REQ-039 stall_i=5'b00011, flush_i=5'b00100 on a valid cycle -> popped entry carries identical flag bits.
REQ-040 rst_i asserted in POST with count_o=5 -> state_o=IDLE, count_o=0 same cycle; rd_en_i after release -> no rd_valid_o.
REQ-041 PIPE_TRACE_TIMESTAMP_EN defined, arm at cycle 10 after reset, valid at cycles 11,13 -> popped timestamps 11 then 13.
